// File: rtl/cs161_run_ctrl_if.sv
// Command, breakpoint and core-control bundle for cs161_run_ctrl.
// The slave modport is the controller; the master is the bench or board glue.
interface cs161_run_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned NUM_BP = 2
);
  logic                     cmd_valid;
  logic [1:0]               cmd_op;
  logic [CNT_W-1:0]         cmd_arg;
  logic                     cmd_ready;
  logic [NUM_BP-1:0]        bp_en;
  logic [NUM_BP*ADDR_W-1:0] bp_addr;
  logic [ADDR_W-1:0]        prog_count;
  logic                     core_rst;
  logic                     core_ce;
  logic [1:0]               state;
  logic [NUM_BP-1:0]        bp_hit;
  logic                     wdog_hit;
  logic                     cmd_err;
  logic [CNT_W-1:0]         cycle_count;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, bp_en, bp_addr, prog_count,
    input  cmd_ready, core_rst, core_ce, state, bp_hit, wdog_hit, cmd_err, cycle_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, bp_en, bp_addr, prog_count,
    output cmd_ready, core_rst, core_ce, state, bp_hit, wdog_hit, cmd_err, cycle_count
  );
endinterface

// File: rtl/cs161_run_ctrl.sv
// Run control for the cs161 core: held reset release, run, N-step, PC breakpoints, cycle count.
// Optional stuck-PC watchdog is built when CS161_RUN_CTRL_WDOG_EN is defined.
module cs161_run_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned RST_HOLD    = 2,
  parameter int unsigned NUM_BP      = 2,
  parameter int unsigned WDOG_CYCLES = 16
) (
  input logic             clk,
  input logic             rst,
  cs161_run_ctrl_if.slave bus
);

  localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  localparam logic [1:0] OP_RUN   = 2'b00;
  localparam logic [1:0] OP_STEP  = 2'b01;
  localparam logic [1:0] OP_HALT  = 2'b10;
  localparam logic [1:0] OP_RESET = 2'b11;

  typedef enum logic [1:0] {
    S_RESET_HOLD = 2'b00,
    S_HALTED     = 2'b01,
    S_RUNNING    = 2'b10,
    S_STEPPING   = 2'b11
  } state_e;

  if (RST_HOLD < 1 || NUM_BP < 1 || WDOG_CYCLES < 1) begin : g_param_check
    $error("cs161_run_ctrl: RST_HOLD, NUM_BP and WDOG_CYCLES must all be at least 1");
  end

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    remain_q, remain_d;
  logic                resume_q, resume_d;
  logic [NUM_BP-1:0]   bp_hit_q, bp_hit_d;
  logic                wdog_hit_q, wdog_hit_d;
  logic                cmd_err_q, cmd_err_d;
  logic [CNT_W-1:0]    cycle_q, cycle_d;
  logic                cmd_ready_q;
  logic                core_rst_q;

  logic [NUM_BP-1:0]   match_vec;
  logic                any_match;
  logic                ce;
  logic                accept;
  logic                wdog_trip;

  // Per-breakpoint PC comparison; this is the only combinational path to core_ce.
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < int'(NUM_BP); i++) begin
      match_vec[i] = bus.bp_en[i] && (bus.prog_count == bus.bp_addr[i*ADDR_W +: ADDR_W]);
    end
  end

  assign any_match = |match_vec;
  assign accept    = bus.cmd_valid && cmd_ready_q;

  // The resume flag lets the first cycle after RUN execute the instruction at a breakpoint.
  always_comb begin
    ce = 1'b0;
    case (state_q)
      S_RUNNING:  ce = !(any_match && !resume_q);
      S_STEPPING: ce = 1'b1;
      default:    ce = 1'b0;
    endcase
  end

`ifdef CS161_RUN_CTRL_WDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_inc;
  logic [ADDR_W-1:0] last_pc_q;

  // A PC change restarts the run of identical PCs at this cycle.
  always_comb begin
    wdog_cnt_inc = wdog_cnt_q + WDOG_W'(1);
    if (wdog_cnt_q != '0 && bus.prog_count != last_pc_q) begin
      wdog_cnt_inc = WDOG_W'(1);
    end
  end

  assign wdog_trip = (state_q == S_RUNNING) && ce && (wdog_cnt_inc == WDOG_W'(WDOG_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt_q <= '0;
      last_pc_q  <= '0;
    end else if (state_q != S_RUNNING || state_d != S_RUNNING) begin
      wdog_cnt_q <= '0;
    end else if (ce) begin
      wdog_cnt_q <= wdog_cnt_inc;
      last_pc_q  <= bus.prog_count;
    end
  end
`else
  assign wdog_trip = 1'b0;
`endif

  // Next-state and flag update; RESET_CORE > HALT > breakpoint > watchdog / step exhaustion.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    remain_d   = remain_q;
    resume_d   = resume_q;
    bp_hit_d   = bp_hit_q;
    wdog_hit_d = wdog_hit_q;
    cmd_err_d  = cmd_err_q;
    cycle_d    = ce ? cycle_q + CNT_W'(1) : cycle_q;

    case (state_q)
      S_RESET_HOLD: begin
        if (hold_q == HOLD_W'(RST_HOLD - 1)) begin
          state_d = S_HALTED;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      S_HALTED: begin
        if (accept) begin
          case (bus.cmd_op)
            OP_RUN: begin
              state_d    = S_RUNNING;
              resume_d   = 1'b1;
              bp_hit_d   = '0;
              wdog_hit_d = 1'b0;
            end
            OP_STEP: begin
              state_d    = S_STEPPING;
              remain_d   = (bus.cmd_arg == '0) ? CNT_W'(1) : bus.cmd_arg;
              bp_hit_d   = '0;
              wdog_hit_d = 1'b0;
            end
            OP_RESET: begin
              state_d    = S_RESET_HOLD;
              hold_d     = '0;
              resume_d   = 1'b0;
              cycle_d    = '0;
              bp_hit_d   = '0;
              wdog_hit_d = 1'b0;
            end
            default: ;
          endcase
        end
      end

      default: begin
        resume_d = 1'b0;
        if (accept && bus.cmd_op == OP_RESET) begin
          state_d    = S_RESET_HOLD;
          hold_d     = '0;
          cycle_d    = '0;
          bp_hit_d   = '0;
          wdog_hit_d = 1'b0;
        end else if (accept && bus.cmd_op == OP_HALT) begin
          state_d = S_HALTED;
        end else begin
          if (accept) begin
            cmd_err_d = 1'b1;
          end
          if (state_q == S_RUNNING) begin
            if (any_match && !resume_q) begin
              state_d  = S_HALTED;
              bp_hit_d = bp_hit_q | match_vec;
            end else if (wdog_trip) begin
              state_d    = S_HALTED;
              wdog_hit_d = 1'b1;
            end
          end else begin
            remain_d = remain_q - CNT_W'(1);
            if (remain_q == CNT_W'(1)) begin
              state_d = S_HALTED;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RESET_HOLD;
      hold_q      <= '0;
      remain_q    <= '0;
      resume_q    <= 1'b0;
      bp_hit_q    <= '0;
      wdog_hit_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
      cycle_q     <= '0;
      cmd_ready_q <= 1'b0;
      core_rst_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      remain_q    <= remain_d;
      resume_q    <= resume_d;
      bp_hit_q    <= bp_hit_d;
      wdog_hit_q  <= wdog_hit_d;
      cmd_err_q   <= cmd_err_d;
      cycle_q     <= cycle_d;
      cmd_ready_q <= (state_d != S_RESET_HOLD);
      core_rst_q  <= (state_d == S_RESET_HOLD);
    end
  end

  assign bus.state       = state_q;
  assign bus.core_rst    = core_rst_q;
  assign bus.core_ce     = ce;
  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.bp_hit      = bp_hit_q;
  assign bus.wdog_hit    = wdog_hit_q;
  assign bus.cmd_err     = cmd_err_q;
  assign bus.cycle_count = cycle_q;

endmodule

// File: tb/tb_cs161_run_ctrl.sv
// Directed bench for cs161_run_ctrl: vector table for the main sequence plus
// hand-written async-reset and watchdog sequences; a small PC model stands in for the core.
module tb_cs161_run_ctrl;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned NUM_BP = 2;

  localparam logic [1:0] OP_RUN   = 2'b00;
  localparam logic [1:0] OP_STEP  = 2'b01;
  localparam logic [1:0] OP_HALT  = 2'b10;
  localparam logic [1:0] OP_RESET = 2'b11;

  logic clk;
  logic rst;

  cs161_run_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .NUM_BP(NUM_BP)) bus ();

  cs161_run_ctrl #(
    .ADDR_W(ADDR_W), .CNT_W(CNT_W), .RST_HOLD(2), .NUM_BP(NUM_BP), .WDOG_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core stand-in: PC clears under core_rst and advances by 4 on every enabled cycle.
  logic [ADDR_W-1:0] pc;
  logic              pc_hold;
  logic [ADDR_W-1:0] pc_hold_val;

  always @(posedge clk) begin
    if (pc_hold)           pc <= pc_hold_val;
    else if (bus.core_rst) pc <= '0;
    else if (bus.core_ce)  pc <= pc + 32'd4;
  end
  assign bus.prog_count = pc;

  int n_vec;
  int n_bad;

  typedef struct {
    logic        valid;
    logic [1:0]  op;
    logic [31:0] arg;
    int          edges;
    logic [1:0]  st;
    logic        ce;
    logic        crst;
    logic [31:0] cyc;
    logic [1:0]  bp;
    logic        err;
    logic [31:0] pcv;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] arg);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_arg   = arg;
    tick(1);
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst           = 1'b1;
    pc            = '0;
    pc_hold       = 1'b0;
    pc_hold_val   = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_HALT;
    bus.cmd_arg   = '0;
    bus.bp_en     = 2'b01;
    bus.bp_addr   = {32'h0000_0048, 32'h0000_0010};

    //            valid op        arg edg st  ce crst cyc bp   err pc
    vecs[0]  = '{1'b1, OP_STEP,  3, 1, 2'd3, 1'b1, 1'b0, 0, 2'b00, 1'b0, 0};
    vecs[1]  = '{1'b0, OP_HALT,  0, 2, 2'd3, 1'b1, 1'b0, 2, 2'b00, 1'b0, 8};
    vecs[2]  = '{1'b0, OP_HALT,  0, 1, 2'd1, 1'b0, 1'b0, 3, 2'b00, 1'b0, 12};
    vecs[3]  = '{1'b1, OP_STEP,  0, 1, 2'd3, 1'b1, 1'b0, 3, 2'b00, 1'b0, 12};
    vecs[4]  = '{1'b0, OP_HALT,  0, 1, 2'd1, 1'b0, 1'b0, 4, 2'b00, 1'b0, 16};
    vecs[5]  = '{1'b1, OP_RESET, 0, 1, 2'd0, 1'b0, 1'b1, 0, 2'b00, 1'b0, 16};
    vecs[6]  = '{1'b0, OP_HALT,  0, 2, 2'd1, 1'b0, 1'b0, 0, 2'b00, 1'b0, 0};
    vecs[7]  = '{1'b1, OP_RUN,   0, 1, 2'd2, 1'b1, 1'b0, 0, 2'b00, 1'b0, 0};
    vecs[8]  = '{1'b0, OP_HALT,  0, 4, 2'd2, 1'b0, 1'b0, 4, 2'b00, 1'b0, 16};
    vecs[9]  = '{1'b0, OP_HALT,  0, 1, 2'd1, 1'b0, 1'b0, 4, 2'b01, 1'b0, 16};
    vecs[10] = '{1'b1, OP_RUN,   0, 1, 2'd2, 1'b1, 1'b0, 4, 2'b00, 1'b0, 16};
    vecs[11] = '{1'b0, OP_HALT,  0, 1, 2'd2, 1'b1, 1'b0, 5, 2'b00, 1'b0, 20};
    vecs[12] = '{1'b1, OP_RUN,   0, 1, 2'd2, 1'b1, 1'b0, 6, 2'b00, 1'b1, 24};
    vecs[13] = '{1'b1, OP_HALT,  0, 1, 2'd1, 1'b0, 1'b0, 7, 2'b00, 1'b1, 28};
    vecs[14] = '{1'b1, OP_RUN,   0, 1, 2'd2, 1'b1, 1'b0, 7, 2'b00, 1'b1, 28};
    vecs[15] = '{1'b0, OP_HALT,  0, 2, 2'd2, 1'b1, 1'b0, 9, 2'b00, 1'b1, 36};
    vecs[16] = '{1'b1, OP_RESET, 0, 1, 2'd0, 1'b0, 1'b1, 0, 2'b00, 1'b1, 40};
    vecs[17] = '{1'b0, OP_HALT,  0, 2, 2'd1, 1'b0, 1'b0, 0, 2'b00, 1'b1, 0};

    // Reset values apply before any clock edge.
    #1;
    chk("rst_state",     64'(bus.state),       64'd0);
    chk("rst_core_rst",  64'(bus.core_rst),    64'd1);
    chk("rst_core_ce",   64'(bus.core_ce),     64'd0);
    chk("rst_cmd_ready", 64'(bus.cmd_ready),   64'd0);
    chk("rst_bp_hit",    64'(bus.bp_hit),      64'd0);
    chk("rst_wdog_hit",  64'(bus.wdog_hit),    64'd0);
    chk("rst_cmd_err",   64'(bus.cmd_err),     64'd0);
    chk("rst_cycles",    64'(bus.cycle_count), 64'd0);

    // Release: two edges of held core reset, then HALTED.
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("hold1_state",    64'(bus.state),       64'd0);
    chk("hold1_core_rst", 64'(bus.core_rst),    64'd1);
    tick(1);
    chk("rel_state",      64'(bus.state),       64'd1);
    chk("rel_core_rst",   64'(bus.core_rst),    64'd0);
    chk("rel_core_ce",    64'(bus.core_ce),     64'd0);
    chk("rel_cycles",     64'(bus.cycle_count), 64'd0);
    chk("rel_cmd_ready",  64'(bus.cmd_ready),   64'd1);

    for (int i = 0; i < 18; i++) begin
      bus.cmd_valid = vecs[i].valid;
      bus.cmd_op    = vecs[i].op;
      bus.cmd_arg   = vecs[i].arg;
      tick(1);
      bus.cmd_valid = 1'b0;
      if (vecs[i].edges > 1) tick(vecs[i].edges - 1);
      chk($sformatf("v%0d_state", i),    64'(bus.state),       64'(vecs[i].st));
      chk($sformatf("v%0d_core_ce", i),  64'(bus.core_ce),     64'(vecs[i].ce));
      chk($sformatf("v%0d_core_rst", i), 64'(bus.core_rst),    64'(vecs[i].crst));
      chk($sformatf("v%0d_cycles", i),   64'(bus.cycle_count), 64'(vecs[i].cyc));
      chk($sformatf("v%0d_bp_hit", i),   64'(bus.bp_hit),      64'(vecs[i].bp));
      chk($sformatf("v%0d_cmd_err", i),  64'(bus.cmd_err),     64'(vecs[i].err));
      chk($sformatf("v%0d_pc", i),       64'(pc),              64'(vecs[i].pcv));
    end

    // Async reset in the middle of a STEP 7 with five steps left.
    send(OP_STEP, 32'd7);
    tick(2);
    chk("mid_step_state",  64'(bus.state),       64'd3);
    chk("mid_step_cycles", 64'(bus.cycle_count), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_core_ce",  64'(bus.core_ce),     64'd0);
    chk("arst_core_rst", 64'(bus.core_rst),    64'd1);
    chk("arst_state",    64'(bus.state),       64'd0);
    chk("arst_cycles",   64'(bus.cycle_count), 64'd0);
    chk("arst_cmd_err",  64'(bus.cmd_err),     64'd0);
    tick(1);
    rst = 1'b0;
    tick(2);
    chk("arst_rel_state", 64'(bus.state), 64'd1);

    // Stuck PC at 0x20 while running.
    pc_hold     = 1'b1;
    pc_hold_val = 32'h20;
    tick(1);
    chk("wd_pc", 64'(pc), 64'h20);
    send(OP_RUN, 32'd0);
`ifdef CS161_RUN_CTRL_WDOG_EN
    tick(7);
    chk("wd_pre_state",  64'(bus.state),       64'd2);
    chk("wd_pre_cycles", 64'(bus.cycle_count), 64'd7);
    tick(1);
    chk("wd_state",  64'(bus.state),       64'd1);
    chk("wd_hit",    64'(bus.wdog_hit),    64'd1);
    chk("wd_cycles", 64'(bus.cycle_count), 64'd8);
    send(OP_RUN, 32'd0);
    chk("wd_clear",  64'(bus.wdog_hit),    64'd0);
`else
    tick(100);
    chk("nowd_state",  64'(bus.state),       64'd2);
    chk("nowd_hit",    64'(bus.wdog_hit),    64'd0);
    chk("nowd_cycles", 64'(bus.cycle_count), 64'd100);
`endif
    send(OP_HALT, 32'd0);
    chk("end_state", 64'(bus.state), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cs161_run_ctrl.md
# cs161_run_ctrl

Parametrised run-control block for the cs161 single-cycle processor, replacing the fixed reset/clock sequencing done by hand in simulation. It sits between the board/bench clock and reset and the processor core, and drives the core's reset and clock enable. It supports held reset release, free run, N-cycle stepping, PC breakpoints and a retired-cycle counter. The same block is used in benches and on hardware.

## Interface
- `ADDR_W`, 32, width of `prog_count` and breakpoint addresses
- `CNT_W`, 32, width of `cmd_arg` and `cycle_count`
- `RST_HOLD`, 2, cycles `core_rst` stays high after `rst` deasserts (≥1)
- `NUM_BP`, 2, number of PC breakpoints (≥1)
- `WDOG_CYCLES`, 16, stuck-PC limit (used only with the watchdog macro)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `cmd_valid` in 1: command strobe
- `cmd_op` in 2: 00 RUN, 01 STEP, 10 HALT, 11 RESET_CORE
- `cmd_arg` in CNT_W: step count for STEP
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`
- `bp_en` in NUM_BP: per-breakpoint enable
- `bp_addr` in NUM_BP*ADDR_W: breakpoint i occupies bits [i*ADDR_W +: ADDR_W]
- `prog_count` in ADDR_W: current PC from the core
- `core_rst` out 1: reset to the core
- `core_ce` out 1: clock enable to the core
- `state` out 2: 00 RESET_HOLD, 01 HALTED, 10 RUNNING, 11 STEPPING
- `bp_hit` out NUM_BP: sticky; bit set for the breakpoint that halted the core
- `wdog_hit` out 1: sticky watchdog halt flag
- `cmd_err` out 1: sticky; set when a command is illegal in the current state
- `cycle_count` out CNT_W: number of cycles with `core_ce`=1; wraps modulo 2^CNT_W

## Operation
- Reset values (`rst`=1, applied immediately and asynchronously):
  - `state`=RESET_HOLD, `core_rst`=1, `core_ce`=0, `cmd_ready`=0
  - `bp_hit`=0, `wdog_hit`=0, `cmd_err`=0, `cycle_count`=0
  - internal hold counter, remaining-step counter and resume flag all cleared
- RESET_HOLD:
  - `core_rst`=1 and `cmd_ready`=0.
  - After RST_HOLD clock edges with `rst` low, go to HALTED. `core_rst` drops on that edge.
- HALTED:
  - `core_ce`=0 and `cmd_ready`=1.
  - RUN: go to RUNNING and set the resume flag.
  - STEP: go to STEPPING with remaining=`cmd_arg`. An arg of 0 is treated as 1.
  - HALT: no-op.
  - RESET_CORE: go to RESET_HOLD; clear `cycle_count`, `bp_hit` and `wdog_hit`.
  - Accepting RUN or STEP clears `bp_hit` and `wdog_hit`.
- RUNNING:
  - A match is `bp_en[i] && prog_count==bp_addr[i]` for any i.
  - `core_ce` = !(match && !resume), combinational.
  - On a match with resume clear: go to HALTED and set `bp_hit[i]` for every matching i. The instruction at the breakpoint is not executed.
  - The resume flag clears after the first RUNNING cycle, so resuming from a breakpoint address executes that instruction.
- STEPPING:
  - `core_ce`=1; breakpoints are ignored.
  - remaining decrements each edge. The edge where remaining==1 goes to HALTED.
- Commands in RUNNING or STEPPING:
  - `cmd_ready`=1.
  - HALT: the current cycle still executes; go to HALTED on the next edge.
  - RESET_CORE: same as from HALTED.
  - RUN or STEP: dropped; set `cmd_err`.
- Priority within one cycle: RESET_CORE > HALT > breakpoint > step-count exhaustion.
- `cycle_count` increments on every edge where `core_ce`=1.

## Timing
- All state transitions occur on the rising edge of `clk`.
- The only combinational paths are `prog_count`/`bp_*` → `core_ce`.
- Command to effect is one edge: `core_ce` rises in the cycle after RUN/STEP is accepted.
- STEP N gives exactly N cycles of `core_ce`=1.
- Deasserting `rst` gives RST_HOLD cycles of `core_rst`=1, then HALTED.
- Asserting `rst` mid-operation forces reset values with no edge required. Counts and flags are lost.

## Configuration
- Macro: `CS161_RUN_CTRL_WDOG_EN`
- Defined:
  - In RUNNING, a counter tracks consecutive `core_ce` cycles with an unchanged `prog_count`.
  - When the counter reaches WDOG_CYCLES: go to HALTED and set `wdog_hit`.
  - Any PC change clears the counter. Leaving RUNNING also clears it.
  - Breakpoints take priority over the watchdog.
- Not defined: `wdog_hit` is tied 0, no counter logic is generated, and `WDOG_CYCLES` is ignored.

## Test plan
- Reset release: `rst` high 2 cycles, then low, with RST_HOLD=2 → `core_rst` high for 2 more edges, then `state`=01, `core_ce`=0, `cycle_count`=0.
- STEP with `cmd_arg`=3 from HALTED → `core_ce` high exactly 3 cycles, `cycle_count`=3, `state`=01. STEP with arg 0 → exactly 1 cycle.
- Breakpoint: PC model starts at 0 and adds 4 per `core_ce`; `bp_addr[0]`=0x10, `bp_en`=01; RUN → halt with `prog_count`=0x10, `cycle_count`=4, `bp_hit`=01. A second RUN executes 0x10 and continues to 0x14.
- Commands while running: HALT during RUN → HALTED on the next edge. RUN issued while RUNNING → `cmd_err`=1, state unchanged. RESET_CORE while RUNNING → RESET_HOLD, `cycle_count`=0.
- Async reset: assert `rst` mid-STEP (remaining=5) between clock edges → `core_ce`=0, `core_rst`=1 and `state`=00 immediately.
- Watchdog (macro defined, WDOG_CYCLES=8): PC held at 0x20, RUN → halt after 8 `core_ce` cycles, `wdog_hit`=1. Macro undefined → still RUNNING after 100 cycles, `wdog_hit`=0.
